// File: rtl/mem_bus_arbiter.sv
// Three-master / one-slave memory arbiter with fetch stall generation,
// m1 starvation guard and slave timeout abort.
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    output logic [31:0] m0_rdata_o,
    output logic        m0_ack_o,

    input  logic        m1_req_i,
    input  logic [31:0] m1_addr_i,
    output logic [31:0] m1_rdata_o,
    output logic        m1_ack_o,

    input  logic        m2_req_i,
    input  logic        m2_we_i,
    input  logic [31:0] m2_addr_i,
    input  logic [31:0] m2_wdata_i,
    output logic [31:0] m2_rdata_o,
    output logic        m2_ack_o,

    output logic        s_req_o,
    output logic        s_we_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_wdata_o,
    input  logic [31:0] s_rdata_i,
    input  logic        s_ack_i,

    output logic        hold_flag_o,
    output logic        bus_err_o
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [2:0]    SMAX = 3'(STARVE_MAX);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [1:0] {G_M0, G_M1, G_M2} grant_t;

    state_t        state_q;
    grant_t        grant_q;
    grant_t        grant_d;
    logic [2:0]    starve_q;
    logic [2:0]    starve_d;
    logic [TW-1:0] timeout_q;
    logic          s_req_q;
    logic          s_we_q;
    logic [31:0]   s_addr_q;
    logic [31:0]   s_wdata_q;
    logic [31:0]   rdata0_q;
    logic [31:0]   rdata1_q;
    logic [31:0]   rdata2_q;
    logic [2:0]    ack_q;
    logic          bus_err_q;

    logic          any_req;
    logic          tmo_hit;
    logic          finish;
    logic [31:0]   cap_data;

    assign any_req  = m0_req_i | m1_req_i | m2_req_i;
    assign tmo_hit  = (timeout_q == TMAX) & ~s_ack_i;
    assign finish   = (state_q == BUSY) & (s_ack_i | tmo_hit);
    assign cap_data = s_ack_i ? s_rdata_i : 32'h0;

    // m2 always first; m1 beats m0 only once m0 has starved it enough
    always_comb begin
        grant_d  = G_M0;
        starve_d = starve_q;
        if (m2_req_i) begin
            grant_d = G_M2;
        end else if (m1_req_i && (starve_q == SMAX || !m0_req_i)) begin
            grant_d = G_M1;
        end
        if (grant_d == G_M1) begin
            starve_d = 3'd0;
        end else if (grant_d == G_M0 && m1_req_i && starve_q != SMAX) begin
            starve_d = starve_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= G_M0;
            starve_q  <= 3'd0;
            timeout_q <= '0;
            s_req_q   <= 1'b0;
            s_we_q    <= 1'b0;
            s_addr_q  <= 32'h0;
            s_wdata_q <= 32'h0;
            rdata0_q  <= 32'h0;
            rdata1_q  <= 32'h0;
            rdata2_q  <= 32'h0;
            ack_q     <= 3'b000;
            bus_err_q <= 1'b0;
        end else begin
            ack_q     <= 3'b000;
            bus_err_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_q   <= BUSY;
                        grant_q   <= grant_d;
                        starve_q  <= starve_d;
                        timeout_q <= '0;
                        s_req_q   <= 1'b1;
                        unique case (grant_d)
                            G_M2: begin
                                s_addr_q  <= m2_addr_i;
                                s_we_q    <= m2_we_i;
                                s_wdata_q <= m2_wdata_i;
                            end
                            G_M1: begin
                                s_addr_q  <= m1_addr_i;
                                s_we_q    <= 1'b0;
                                s_wdata_q <= 32'h0;
                            end
                            default: begin
                                s_addr_q  <= m0_addr_i;
                                s_we_q    <= m0_we_i;
                                s_wdata_q <= m0_wdata_i;
                            end
                        endcase
                    end
                end
                BUSY: begin
                    if (finish) begin
                        state_q   <= DONE;
                        s_req_q   <= 1'b0;
                        s_we_q    <= 1'b0;
                        bus_err_q <= ~s_ack_i;
                        ack_q     <= 3'b001 << grant_q;
                        unique case (grant_q)
                            G_M2:    rdata2_q <= cap_data;
                            G_M1:    rdata1_q <= cap_data;
                            default: rdata0_q <= cap_data;
                        endcase
                    end else begin
                        timeout_q <= timeout_q + TW'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // a reset landing on the DONE cycle must swallow the completion pulse
    assign m0_ack_o    = ack_q[0] & ~rst;
    assign m1_ack_o    = ack_q[1] & ~rst;
    assign m2_ack_o    = ack_q[2] & ~rst;
    assign bus_err_o   = bus_err_q & ~rst;

    assign m0_rdata_o  = rdata0_q;
    assign m1_rdata_o  = rdata1_q;
    assign m2_rdata_o  = rdata2_q;

    assign s_req_o     = s_req_q;
    assign s_we_o      = s_we_q;
    assign s_addr_o    = s_addr_q;
    assign s_wdata_o   = s_wdata_q;

    assign hold_flag_o = m1_req_i & ~(state_q == DONE && grant_q == G_M1);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: transaction-level masters and slave with a
// reference model of grants, completions and timeouts.
module tb_mem_bus_arbiter;

    localparam int TMO  = 8;
    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req_i, m0_we_i;
    logic [31:0] m0_addr_i, m0_wdata_i, m0_rdata_o;
    logic        m0_ack_o;
    logic        m1_req_i;
    logic [31:0] m1_addr_i, m1_rdata_o;
    logic        m1_ack_o;
    logic        m2_req_i, m2_we_i;
    logic [31:0] m2_addr_i, m2_wdata_i, m2_rdata_o;
    logic        m2_ack_o;
    logic        s_req_o, s_we_o;
    logic [31:0] s_addr_o, s_wdata_o, s_rdata_i;
    logic        s_ack_i;
    logic        hold_flag_o, bus_err_o;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.TIMEOUT(TMO), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i),
        .m0_wdata_i(m0_wdata_i), .m0_rdata_o(m0_rdata_o), .m0_ack_o(m0_ack_o),
        .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i),
        .m1_rdata_o(m1_rdata_o), .m1_ack_o(m1_ack_o),
        .m2_req_i(m2_req_i), .m2_we_i(m2_we_i), .m2_addr_i(m2_addr_i),
        .m2_wdata_i(m2_wdata_i), .m2_rdata_o(m2_rdata_o), .m2_ack_o(m2_ack_o),
        .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o),
        .s_wdata_o(s_wdata_o), .s_rdata_i(s_rdata_i), .s_ack_i(s_ack_i),
        .hold_flag_o(hold_flag_o), .bus_err_o(bus_err_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // masters: one outstanding transaction each
    logic        pv[3];
    logic        pwe[3];
    logic [31:0] pad[3];
    logic [31:0] pwd[3];
    bit          cont[3];
    int          log_q[$];
    int          err_seen;
    int          wr_busy;

    // slave behaviour: 0 random waits, 1 fixed waits, 2 never acks
    int          slave_mode;
    int          fix_wait;
    bit          fix_rd_en;
    logic [31:0] fix_rd;
    bit          noise;
    logic        rst_drv;
    logic        d_ack;
    logic [31:0] d_rdata;

    // reference model: what the bus is doing in the current cycle
    typedef enum int {PI, PB, PD} ph_t;
    ph_t         ph;
    int          g, bidx, wsel, starve;
    bit          eerr;
    logic [31:0] rd[3];
    logic [31:0] la, lwd;
    logic        lwe;

    task automatic post(input int i, input bit we, input logic [31:0] a,
                        input logic [31:0] d);
        pv[i]  = 1'b1;
        pwe[i] = (i == 1) ? 1'b0 : we;
        pad[i] = a;
        pwd[i] = (i == 1) ? 32'h0 : d;
    endtask

    function automatic int logv(input int i);
        return (i < log_q.size()) ? log_q[i] : -1;
    endfunction

    task automatic drive();
        rst        = rst_drv;
        m0_req_i   = pv[0];
        m0_we_i    = pwe[0];
        m0_addr_i  = pad[0];
        m0_wdata_i = pwd[0];
        m1_req_i   = pv[1];
        m1_addr_i  = pad[1];
        m2_req_i   = pv[2];
        m2_we_i    = pwe[2];
        m2_addr_i  = pad[2];
        m2_wdata_i = pwd[2];
        d_rdata    = fix_rd_en ? fix_rd : $urandom;
        if (ph == PB) d_ack = (bidx == wsel);
        else          d_ack = noise && ($urandom_range(0, 1) == 1);
        s_ack_i    = d_ack;
        s_rdata_i  = d_rdata;
    endtask

    task automatic observe();
        logic [2:0] eack;
        logic [2:0] oack;
        bit         busy;
        bit         dn;
        int         w;
        busy = (ph == PB);
        dn   = (ph == PD) && !rst_drv;
        check("s_req", 32'(s_req_o), 32'(busy));
        if (busy) begin
            check("s_addr", s_addr_o, la);
            check("s_we", 32'(s_we_o), 32'(lwe));
            if (lwe) check("s_wdata", s_wdata_o, lwd);
        end
        eack = dn ? (3'b001 << g) : 3'b000;
        oack = {m2_ack_o, m1_ack_o, m0_ack_o};
        check("ack", 32'(oack), 32'(eack));
        check("bus_err", 32'(bus_err_o), 32'(dn && eerr));
        check("hold", 32'(hold_flag_o), 32'(pv[1] && !(ph == PD && g == 1)));
        check("m0_rdata", m0_rdata_o, rd[0]);
        check("m1_rdata", m1_rdata_o, rd[1]);
        check("m2_rdata", m2_rdata_o, rd[2]);
        if (s_req_o && s_we_o && s_wdata_o == 32'hDEADBEEF) wr_busy++;
        if (bus_err_o) err_seen++;
        for (int i = 0; i < 3; i++) begin
            if (oack[i]) begin
                log_q.push_back(i);
                pv[i] = 1'b0;
                if (cont[i]) post(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
            end
        end
        if (rst_drv) begin
            ph = PI;
            starve = 0;
            for (int i = 0; i < 3; i++) rd[i] = 32'h0;
        end else begin
            case (ph)
                PI: begin
                    if (m2_req_i) w = 2;
                    else if (m1_req_i && (starve == SMAX || !m0_req_i)) w = 1;
                    else if (m0_req_i) w = 0;
                    else w = -1;
                    if (w >= 0) begin
                        if (w == 0 && m1_req_i && starve < SMAX) starve++;
                        if (w == 1) starve = 0;
                        g    = w;
                        la   = pad[w];
                        lwe  = pwe[w];
                        lwd  = pwd[w];
                        bidx = 0;
                        ph   = PB;
                        if (slave_mode == 0)      wsel = $urandom_range(0, 3);
                        else if (slave_mode == 1) wsel = fix_wait;
                        else                      wsel = 1000000;
                    end
                end
                PB: begin
                    // ack wins; otherwise TMO+1 silent busy cycles abort
                    if (d_ack) begin
                        rd[g] = d_rdata;
                        eerr  = 1'b0;
                        ph    = PD;
                    end else if (bidx == TMO) begin
                        rd[g] = 32'h0;
                        eerr  = 1'b1;
                        ph    = PD;
                    end else begin
                        bidx++;
                    end
                end
                default: ph = PI;
            endcase
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        observe();
    endtask

    task automatic drain(input int lim);
        int k = 0;
        while ((pv[0] || pv[1] || pv[2] || ph != PI) && k < lim) begin
            step();
            k++;
        end
        check("drain_in_budget", 32'(k < lim), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            pv[i] = 1'b0; pwe[i] = 1'b0; pad[i] = '0; pwd[i] = '0;
            cont[i] = 1'b0; rd[i] = '0;
        end
        ph = PI; g = 0; bidx = 0; wsel = 0; starve = 0; eerr = 1'b0;
        la = '0; lwd = '0; lwe = 1'b0;
        slave_mode = 0; fix_wait = 0; fix_rd_en = 1'b0; fix_rd = '0;
        noise = 1'b0; err_seen = 0; wr_busy = 0;
        rst = 1'b1; rst_drv = 1'b1;
        m0_req_i = 0; m0_we_i = 0; m0_addr_i = '0; m0_wdata_i = '0;
        m1_req_i = 0; m1_addr_i = '0;
        m2_req_i = 0; m2_we_i = 0; m2_addr_i = '0; m2_wdata_i = '0;
        s_ack_i = 0; s_rdata_i = '0;
        repeat (2) @(posedge clk);
        step();
        step();
        rst_drv = 1'b0;

        // single zero-wait fetch
        slave_mode = 1; fix_wait = 0; fix_rd_en = 1'b1; fix_rd = 32'h13;
        post(1, 0, 32'h0000_0100, 32'h0);
        repeat (4) step();
        check("fetch_rdata", m1_rdata_o, 32'h13);
        check("fetch_n", 32'(log_q.size()), 32'd1);
        check("fetch_who", 32'(logv(0)), 32'd1);

        // simultaneous requests
        log_q.delete();
        slave_mode = 0; fix_rd_en = 1'b0;
        post(0, 1, 32'h1000_0000, 32'h1111_0000);
        post(1, 0, 32'h1000_0040, 32'h0);
        post(2, 0, 32'h1000_0080, 32'h0);
        drain(60);
        check("simul_n", 32'(log_q.size()), 32'd3);
        check("simul_0", 32'(logv(0)), 32'd2);
        check("simul_1", 32'(logv(1)), 32'd0);
        check("simul_2", 32'(logv(2)), 32'd1);

        // starvation: m0 and m1 both request continuously
        log_q.delete();
        cont[0] = 1'b1; cont[1] = 1'b1;
        post(0, 0, 32'h1200_0000, 32'h0);
        post(1, 0, 32'h1300_0000, 32'h0);
        for (int k = 0; k < 150 && log_q.size() < 6; k++) step();
        cont[0] = 1'b0; cont[1] = 1'b0;
        check("starve_n", 32'(log_q.size() >= 6), 32'd1);
        for (int i = 0; i < 6; i++)
            check("starve_seq", 32'(logv(i)), (i == 4) ? 32'd1 : 32'd0);
        drain(60);

        // timeout on an m0 write
        log_q.delete(); err_seen = 0; slave_mode = 2;
        post(0, 1, 32'h3000_0010, 32'h5555_AAAA);
        drain(30);
        check("tmo_n", 32'(log_q.size()), 32'd1);
        check("tmo_rdata", m0_rdata_o, 32'h0);
        check("tmo_err", 32'(err_seen), 32'd1);

        // ack on the last cycle before abort wins
        err_seen = 0; slave_mode = 1; fix_wait = TMO;
        fix_rd_en = 1'b1; fix_rd = 32'hCAFE_0001;
        post(2, 0, 32'h3000_0020, 32'h0);
        drain(30);
        check("edge_err", 32'(err_seen), 32'd0);
        check("edge_rdata", m2_rdata_o, 32'hCAFE_0001);

        // debug write with 3 wait states
        wr_busy = 0; fix_wait = 3; fix_rd = 32'h0BAD_F00D;
        post(2, 1, 32'h2000_0000, 32'hDEAD_BEEF);
        drain(20);
        check("wr_busy", 32'(wr_busy), 32'd4);
        check("wr_rdata", m2_rdata_o, 32'h0BAD_F00D);

        // reset in the second busy cycle of an m0 read
        log_q.delete(); slave_mode = 2; fix_rd_en = 1'b0;
        post(0, 0, 32'h4000_0000, 32'h0);
        step();
        step();
        rst_drv = 1'b1;
        step();
        rst_drv = 1'b0;
        slave_mode = 0;
        drain(40);
        check("rstb_n", 32'(log_q.size()), 32'd1);
        check("rstb_who", 32'(logv(0)), 32'd0);

        // reset on the DONE cycle of a fetch
        log_q.delete(); slave_mode = 1; fix_wait = 0;
        post(1, 0, 32'h4000_0100, 32'h0);
        step();
        step();
        check("rstd_phase", 32'(ph == PD), 32'd1);
        rst_drv = 1'b1;
        step();
        rst_drv = 1'b0;
        drain(40);
        check("rstd_n", 32'(log_q.size()), 32'd1);

        // random traffic with stray acks outside BUSY
        slave_mode = 0; noise = 1'b1;
        for (int k = 0; k < 500; k++) begin
            for (int i = 0; i < 3; i++)
                if (!pv[i] && $urandom_range(0, 3) == 0)
                    post(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
            step();
        end
        noise = 1'b0;
        drain(100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
